notch_sample_fifo: RTL

Downstream consumer of the IIR notch filter. It accepts each IEEE-754 single-precision filter result over a level-valid/ack handshake and converts it to a saturated signed 16-bit fixed-point sample. Converted samples are buffered in a small FIFO and presented on a first-word-fall-through valid/ack interface to the host-side transmitter (SPI/UART framer). It decouples the slow, irregular filter output from bursty readout and guarantees exactly one FIFO entry per filter result.

---
 rtl/filter_pkg.sv | 53 +++++
 rtl/sample_fifo.sv | 52 +++++
 rtl/notch_sample_fifo.sv | 88 ++++++++
 3 files changed

// File: rtl/filter_pkg.sv
// Shared constants, FSM state type and float-to-int16 conversion for the
// notch filter output path.
package filter_pkg;

  localparam int FLOAT_BIAS   = 127;
  localparam int FLOAT_MANT_W = 23;
  localparam logic [15:0] INT16_MAX = 16'h7FFF;
  localparam logic [15:0] INT16_MIN = 16'h8000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CONVERT,
    ST_PUSH,
    ST_WAIT_LOW
  } notch_sample_fifo_state_t;

  typedef struct packed {
    logic [15:0] value;
    logic        sat;
  } conv_result_t;

  // trunc(f * 2^scale_exp) clipped to int16; sat flags NaN, inf and clipping
  function automatic conv_result_t float_to_int16(input logic [31:0] f,
                                                  input int scale_exp);
    conv_result_t r;
    logic         sgn;
    logic [7:0]   e;
    logic [22:0]  m;
    logic [23:0]  mag;
    int           k;
    sgn     = f[31];
    e       = f[30:23];
    m       = f[22:0];
    k       = int'(e) - FLOAT_BIAS + scale_exp;
    mag     = '0;
    r.value = '0;
    r.sat   = 1'b0;
    if (e == 8'hFF) begin
      r.sat = 1'b1;
      if (m == '0) r.value = sgn ? INT16_MIN : INT16_MAX;
    end else if (e == 8'h00 || k < 0) begin
      r.value = '0;
    end else if (k >= 15) begin
      r.value = sgn ? INT16_MIN : INT16_MAX;
      r.sat   = !(sgn && k == 15 && m == '0);
    end else begin
      mag     = {1'b1, m} >> (FLOAT_MANT_W - k);
      r.value = sgn ? (~mag[15:0] + 16'd1) : mag[15:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// First-word-fall-through FIFO of 16-bit samples with level and full flags.
module sample_fifo #(
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [15:0]                push_data,
  input  logic                       pop,
  output logic [15:0]                head,
  output logic                       not_empty,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = $clog2(DEPTH + 1);

  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] count;
  logic          do_pop;

  assign do_pop    = pop && (count != '0);
  assign not_empty = (count != '0);
  assign full      = (count == LW'(DEPTH));
  assign level     = count;
  // Empty FIFO presents zero so the head reads as 0 out of reset.
  assign head      = not_empty ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/notch_sample_fifo.sv
// Captures float filter results over a level handshake, converts them to
// saturated int16 and buffers them in an FWFT FIFO for the host transmitter.
module notch_sample_fifo
  import filter_pkg::*;
#(
  parameter int unsigned DEPTH     = 8,
  parameter int          SCALE_EXP = 15
) (
  input  logic                       i_CLK,
  input  logic                       i_RSTN,
  input  logic [31:0]                i_result,
  input  logic                       i_result_valid,
  output logic                       o_result_ack,
  output logic [15:0]                o_sample,
  output logic                       o_sample_valid,
  input  logic                       i_sample_ack,
  output logic                       o_full,
  output logic [$clog2(DEPTH+1)-1:0] o_level,
  output logic [7:0]                 o_sat_cnt
);

  notch_sample_fifo_state_t state, next_state;
  logic [31:0]  captured;
  logic [15:0]  conv_reg;
  logic         capture_en;
  logic         push;
  conv_result_t conv;

  always_comb begin
    conv = float_to_int16(captured, SCALE_EXP);
  end

  always_comb begin
    next_state = state;
    capture_en = 1'b0;
    push       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (i_result_valid && !o_full) begin
          capture_en = 1'b1;
          next_state = ST_CONVERT;
        end
      end
      ST_CONVERT: next_state = ST_PUSH;
      ST_PUSH: begin
        push       = 1'b1;
        next_state = i_result_valid ? ST_WAIT_LOW : ST_IDLE;
      end
      ST_WAIT_LOW: begin
        if (!i_result_valid) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_CLK or negedge i_RSTN) begin
    if (!i_RSTN) begin
      state        <= ST_IDLE;
      captured     <= '0;
      conv_reg     <= '0;
      o_result_ack <= 1'b0;
      o_sat_cnt    <= '0;
    end else begin
      state        <= next_state;
      o_result_ack <= (state == ST_CONVERT);
      if (capture_en) captured <= i_result;
      if (state == ST_CONVERT) begin
        conv_reg <= conv.value;
        if (conv.sat && o_sat_cnt != 8'hFF) o_sat_cnt <= o_sat_cnt + 8'd1;
      end
    end
  end

  sample_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (i_CLK),
    .rst_n     (i_RSTN),
    .push      (push),
    .push_data (conv_reg),
    .pop       (i_sample_ack),
    .head      (o_sample),
    .not_empty (o_sample_valid),
    .full      (o_full),
    .level     (o_level)
  );

endmodule
